n_way_mux_arb: RTL and testbench
================================

Name: n_way_mux_arb

Overview:
- Parametrised successor to the processor's 2-way 16-bit mux.
- Selects one of NUM_IN WIDTH-bit channels, either by explicit select or by round-robin arbitration.
- Holds the chosen word in a one-entry output register with valid/ready handshakes on both sides.
- Sits between multiple datapath producers (ALU, memory, immediate, PC paths) and a single consumer that may stall.

Parameters:
- WIDTH, 16: data width of each channel in bits.
- NUM_IN, 4: number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN): select and grant index width. Derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_IN  per-channel data-valid.
- in_data  input  NUM_IN*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-channel accept; one-hot or zero.
- mode  input  1  0 = fixed select (uses sel), 1 = round-robin.
- sel  input  SEL_W  channel index used when mode = 0.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Clock and reset:
  - Single clock domain; reset sampled on the rising edge of clk and dominates all other inputs.
- Reset values:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - last_grant = NUM_IN-1, so input 0 has first round-robin priority.
  - in_ready = 0 during reset.
- Load condition:
  - load_en = !out_valid || out_ready (combinational).
- Grant, combinational, evaluated only when load_en = 1:
  - mode 0: grant = sel if sel < NUM_IN and in_valid[sel] = 1; otherwise no grant.
  - mode 1: scan channels (last_grant+1) mod NUM_IN upward with wrap; grant the first with in_valid = 1. If in_valid is all zero, no grant.
- in_ready[i] = load_en && granted && grant == i. in_ready has no dependency on any in_valid other than the granted channel's path through the picker.
- Input transfer:
  - Channel i transfers when in_valid[i] && in_ready[i].
  - Next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1, last_grant <= i.
- Output drain:
  - If out_valid && out_ready and there is no grant this cycle, out_valid <= 0. out_data and out_sel hold their last values.
- Stall:
  - If out_valid && !out_ready, all outputs hold and in_ready = 0.
- Throughput and latency:
  - Simultaneous pop and load gives 1 word/cycle sustained.
  - Latency from input transfer to out_valid is exactly 1 cycle.
- last_grant updates only on a transfer, in both modes. A mode switch mid-stream takes effect on the next arbitration, and round-robin resumes from the retained last_grant.
- Reset asserted while out_valid = 1 discards the buffered word; no transfer occurs in that cycle.
- NUM_IN not a power of 2: out-of-range sel produces no grant; the round-robin wrap uses modulo NUM_IN, never 2^SEL_W.
- Inputs may drop in_valid without a transfer; no input-side hold requirement is imposed.

Optional Feature:
- Macro: MUX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Increments each cycle out_valid && !out_ready; saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined:
  - Port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - DEFAULT_WIDTH = 16, DEFAULT_NUM_IN = 4.
  - STALL_CNT_W = 16.
- Sub-module rr_priority_pick:
  - Purely combinational.
  - Inputs: req[NUM_IN], last[SEL_W].
  - Outputs: gnt_valid, gnt_idx[SEL_W].
  - Implemented as a rotate, first-one find, then un-rotate.
- The top level owns the output register, last_grant, handshake logic and the optional counter.

Test Plan (WIDTH=16, NUM_IN=4):
- Reset mid-stream: load 16'h1234, hold out_ready=0, assert reset one cycle -> next cycle out_valid=0, out_data=0, out_sel=0, in_ready=0.
- Fixed select with 2-way equivalence: mode=0, sel=1, in_data ch0=16'h0000, ch1=16'h0001, all valid, out_ready=1 -> one cycle later out_data=16'h0001, out_sel=1. With sel=0 -> out_data=16'h0000, out_sel=0.
- Round-robin fairness: mode=1, all 4 valid, ch i data = 16'hA000+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data tracks 16'hA000..A003.
- Back-pressure: out_ready=0 for 3 cycles after a load of 16'h00FF -> out_data stays 16'h00FF and in_ready=0 throughout. Release -> next word accepted on the release cycle. With MUX_STALL_CNT_EN defined -> stall_cnt=3.
- Sparse requests with wrap: mode=1, last_grant=2, only ch1 valid -> grant ch1 (wraps past 3,0). Then only ch3 valid -> grant ch3. in_valid=0 with out_ready=1 -> out_valid falls to 0.
- Invalid select: mode=0, sel=2, in_valid=4'b1011 -> in_ready=0 and out_valid stays 0. Switch to mode=1 same cycle -> grant ch3 (after last_grant=2) or ch0, per the retained last_grant.

Source files
------------

// File: rtl/n_way_mux_arb_pkg.sv
// Shared constants for the N-way mux/arbiter.
// Mode encodings, default geometry and stall counter width.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_NUM_IN = 4;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/n_way_mux_arb_pick.sv
// rr_priority_pick: combinational round-robin picker.
// Ports: req (requests), last (previous grant) -> gnt_valid, gnt_idx.
module rr_priority_pick
  import mux_pkg::*;
#(
  parameter  int NUM_IN = DEFAULT_NUM_IN,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [NUM_IN-1:0] rot;
  int                start;
  int                first;

  // Rotate so the slot after last sits at bit 0, find the
  // lowest set bit, then map back. Wrap is modulo NUM_IN.
  always_comb begin
    start = (int'(last) + 1) % NUM_IN;
    rot   = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      rot[j] = req[(j + start) % NUM_IN];
    end
    gnt_valid = 1'b0;
    first     = 0;
    for (int j = NUM_IN - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_valid = 1'b1;
        first     = j;
      end
    end
    gnt_idx = SEL_W'((first + start) % NUM_IN);
  end

endmodule

// File: rtl/n_way_mux_arb.sv
// n_way_mux_arb: NUM_IN x WIDTH mux/arbiter with a one-entry output
// register. Ports: in_valid/in_data/in_ready per channel, mode/sel
// select control, out_valid/out_data/out_sel/out_ready output side.
// Optional MUX_STALL_CNT_EN adds a saturating 16-bit stall_cnt port.
module n_way_mux_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int NUM_IN = DEFAULT_NUM_IN,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
`ifdef MUX_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cnt
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [SEL_W-1:0]  last_q, last_d;

  logic              load_en;
  logic              fix_hit;
  logic              rr_valid;
  logic [SEL_W-1:0]  rr_idx;
  logic              granted;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  gnt_data;

  rr_priority_pick #(
    .NUM_IN (NUM_IN)
  ) u_pick (
    .req       (in_valid),
    .last      (last_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Compare against every legal index so an out-of-range
  // sel simply matches nothing.
  always_comb begin
    fix_hit = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) fix_hit = in_valid[i];
    end
  end

  always_comb begin
    load_en   = !out_valid_q || out_ready;
    granted   = 1'b0;
    grant_idx = sel;
    unique case (1'b1)
      (mode == MODE_RR): begin
        granted   = rr_valid;
        grant_idx = rr_idx;
      end
      default: begin
        granted   = fix_hit;
        grant_idx = sel;
      end
    endcase
    granted = granted && load_en && !reset;
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = granted;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A grant always implies the chosen channel is valid,
  // so granted alone marks a transfer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (granted) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = grant_idx;
      last_d      = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(NUM_IN - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef MUX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_n_way_mux_arb.sv
// Testbench for n_way_mux_arb (WIDTH=16, NUM_IN=4).
// Scoreboard of expected words, reference arbiter model.
module tb_n_way_mux_arb;

  localparam int W = 16;
  localparam int N = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;
`ifdef MUX_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  n_way_mux_arb #(
    .WIDTH  (W),
    .NUM_IN (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
  } word_t;

  word_t         exp_q[$];
  logic [SW-1:0] got_sel[$];
  logic [W-1:0]  got_data[$];
  bit            rec;

  int n_chk;
  int n_fail;

  logic          m_valid;
  logic [SW-1:0] m_last;
  logic [W-1:0]  m_data;
  logic [SW-1:0] m_sel;
  int            m_stall;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = SW'(N - 1);
    m_data  = '0;
    m_sel   = '0;
    m_stall = 0;
    exp_q.delete();
  endtask

  // One clock: check at negedge against the model, then
  // advance the model to the state after the next posedge.
  task automatic cycle();
    logic         load, g_ok;
    int           g;
    logic [N-1:0] exp_rdy;
    word_t        w;
    @(negedge clk);
    if (reset) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      model_reset();
    end else begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
`ifdef MUX_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0].data));
          check("out_sel", 32'(out_sel), 32'(exp_q[0].sel));
          if (out_ready) begin
            w = exp_q.pop_front();
            m_data = w.data;
            m_sel  = w.sel;
            if (rec) begin
              got_sel.push_back(out_sel);
              got_data.push_back(out_data);
            end
          end
        end
        if (!out_ready && m_stall < 16'hFFFF) m_stall++;
      end else begin
        check("hold_data", 32'(out_data), 32'(m_data));
        check("hold_sel", 32'(out_sel), 32'(m_sel));
      end
      load = !m_valid || out_ready;
      g_ok = 1'b0;
      g    = 0;
      if (mode) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (int'(m_last) + k) % N;
          if (!g_ok && in_valid[c]) begin
            g_ok = 1'b1;
            g    = c;
          end
        end
      end else if (int'(sel) < N && in_valid[sel]) begin
        g_ok = 1'b1;
        g    = int'(sel);
      end
      g_ok    = g_ok && load;
      exp_rdy = '0;
      if (g_ok) exp_rdy[g] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (g_ok) begin
        w.data = in_data[g*W +: W];
        w.sel  = SW'(g);
        exp_q.push_back(w);
        m_valid = 1'b1;
        m_last  = SW'(g);
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rec       = 1'b0;
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    cycle();

    // Reset mid-stream discards a stalled word.
    mode = 1'b0; sel = 2'd0;
    set_ch(0, 16'h1234);
    in_valid = 4'b0001;
    cycle();
    in_valid = '0;
    cycle();
    check("loaded_1234", 32'(out_data), 32'h1234);
    reset = 1'b1;
    in_valid = 4'b0001;
    cycle();
    reset = 1'b0;
    in_valid = '0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    cycle();

    // Fixed select, 2-way equivalence.
    out_ready = 1'b1;
    set_ch(0, 16'h0000); set_ch(1, 16'h0001);
    set_ch(2, 16'h0002); set_ch(3, 16'h0003);
    in_valid = 4'b1111;
    sel = 2'd1;
    cycle();
    check("fix1_data", 32'(out_data), 32'h0001);
    check("fix1_sel", 32'(out_sel), 32'd1);
    sel = 2'd0;
    cycle();
    check("fix0_data", 32'(out_data), 32'h0000);
    check("fix0_sel", 32'(out_sel), 32'd0);
    in_valid = '0;
    cycle();

    // Round-robin fairness from reset priority.
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, W'(16'hA000 + i));
    in_valid = 4'b1111;
    rec = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    in_valid = '0;
    cycle();
    rec = 1'b0;
    check("rr_count", 32'(got_sel.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_sel.size(); i++) begin
      check("rr_sel", 32'(got_sel[i]), 32'(i % 4));
      check("rr_data", 32'(got_data[i]), 32'(16'hA000 + i % 4));
    end
    cycle();

    // Back-pressure.
    do_reset();
    mode = 1'b0; sel = 2'd0;
    set_ch(0, 16'h00FF);
    in_valid = 4'b0001;
    cycle();
    out_ready = 1'b0;
    set_ch(0, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_data", 32'(out_data), 32'h00FF);
    end
`ifdef MUX_STALL_CNT_EN
    check("bp_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    out_ready = 1'b1;
    cycle();
    check("bp_next", 32'(out_data), 32'h0100);
    in_valid = '0;
    cycle();

    // Sparse round-robin with wrap.
    sel = 2'd2;
    for (int i = 0; i < N; i++) set_ch(i, W'(16'h5000 + i));
    in_valid = 4'b0100;
    cycle();
    mode = 1'b1;
    in_valid = 4'b0010;
    cycle();
    check("wrap_sel1", 32'(out_sel), 32'd1);
    in_valid = 4'b1000;
    cycle();
    check("wrap_sel3", 32'(out_sel), 32'd3);
    in_valid = '0;
    cycle();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Invalid fixed select, then switch to round-robin.
    mode = 1'b0; sel = 2'd2;
    in_valid = 4'b1011;
    cycle();
    check("nosel_valid", 32'(out_valid), 32'd0);
    mode = 1'b1;
    cycle();
    check("switch_sel", 32'(out_sel), 32'd0);
    in_valid = '0;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom};
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    reset = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
